// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiply unit.
//   mul_op_e    : RV32M multiply mode carried with each issued op
//   MUL_OP_BW   : width of the mode field
//   MUL_DATA_W  : operand/result width the unit is built for
//   mul_select  : extend both operands, multiply, and pick the low or high
//                 half of the product according to the mode
package mul_pkg;

   localparam int MUL_OP_BW  = 2;
   localparam int MUL_DATA_W = 32;

   typedef enum logic [MUL_OP_BW-1:0] {
      MUL_LO    = 2'd0,
      MUL_HI_SS = 2'd1,
      MUL_HI_SU = 2'd2,
      MUL_HI_UU = 2'd3
   } mul_op_e;

   // One extra bit per operand lets every mode share a single signed
   // multiplier: unsigned operands get a 0 in the extra bit.
   function automatic logic [MUL_DATA_W-1:0] mul_select(
      input mul_op_e                 op,
      input logic [MUL_DATA_W-1:0]   a,
      input logic [MUL_DATA_W-1:0]   b
   );
      logic signed [MUL_DATA_W:0]     a_x;
      logic signed [MUL_DATA_W:0]     b_x;
      logic signed [2*MUL_DATA_W+1:0] prod;
      logic                           a_sgn;
      logic                           b_sgn;
      a_sgn = (op != MUL_HI_UU);
      b_sgn = (op == MUL_LO) || (op == MUL_HI_SS);
      a_x   = signed'({a_sgn & a[MUL_DATA_W-1], a});
      b_x   = signed'({b_sgn & b[MUL_DATA_W-1], b});
      prod  = a_x * b_x;
      if (op == MUL_LO) begin
         return prod[MUL_DATA_W-1:0];
      end
      return prod[2*MUL_DATA_W-1:MUL_DATA_W];
   endfunction

endpackage

// File: rtl/mul_pipe_unit_if.sv
// Issue / result bus of the multiply unit.
//   i_rsv_*  : issue request from the reservation station (valid/ready)
//   i_flush  : kill all in-flight ops
//   o_cdb_*  : result broadcast toward the CDB (valid/ready)
//   o_busy   : any stage holds a valid op
// Modports: master = reservation station / CDB side, slave = the unit.
interface mul_pipe_unit_if #(
   parameter int BW_PROCESSOR_DATA = 32,
   parameter int BW_TAG            = 1
) ();

   logic                           i_rsv_valid;
   logic                           i_rsv_ready;
   logic [BW_TAG-1:0]              i_rsv_tag;
   logic [mul_pkg::MUL_OP_BW-1:0]  i_rsv_op;
   logic [2*BW_PROCESSOR_DATA-1:0] i_rsv_V_flatten;
   logic                           i_flush;
   logic                           o_cdb_valid;
   logic                           o_cdb_ready;
   logic [BW_TAG-1:0]              o_cdb_tag;
   logic [BW_PROCESSOR_DATA-1:0]   o_cdb_wdata;
   logic                           o_busy;

   modport master (
      output i_rsv_valid, i_rsv_tag, i_rsv_op, i_rsv_V_flatten, i_flush, o_cdb_ready,
      input  i_rsv_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata, o_busy
   );

   modport slave (
      input  i_rsv_valid, i_rsv_tag, i_rsv_op, i_rsv_V_flatten, i_flush, o_cdb_ready,
      output i_rsv_ready, o_cdb_valid, o_cdb_tag, o_cdb_wdata, o_busy
   );

endinterface

// File: rtl/pipe_stage_slice.sv
// One register stage of an elastic pipeline with bubble collapsing.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_valid     : upstream stage (or issue port) holds an op
//   i_payload   : upstream payload
//   i_adv_next  : downstream stage can take this stage's content
//   i_flush     : drop the content of this stage
//   o_valid     : this stage holds an op
//   o_payload   : this stage's payload
//   o_adv       : this stage loads from upstream at the next edge
module pipe_stage_slice #(
   parameter int PAYLOAD_BW = 33
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   input  logic [PAYLOAD_BW-1:0] i_payload,
   input  logic                  i_adv_next,
   input  logic                  i_flush,
   output logic                  o_valid,
   output logic [PAYLOAD_BW-1:0] o_payload,
   output logic                  o_adv
);

   logic                  valid_q;
   logic                  valid_d;
   logic [PAYLOAD_BW-1:0] payload_q;
   logic [PAYLOAD_BW-1:0] payload_d;

   // An empty stage always accepts, so bubbles are squeezed out even when
   // everything downstream is stalled.
   assign o_adv = !valid_q || i_adv_next;

   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      if (o_adv) begin
         valid_d   = i_valid;
         payload_d = i_payload;
      end
      if (i_flush) begin
         valid_d = 1'b0;
      end
   end

   // Payload is reset too: the last stage drives the result bus directly
   // and that bus must read zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign o_valid   = valid_q;
   assign o_payload = payload_q;

endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined integer multiply functional unit (RV32M MUL/MULH/MULHSU/MULHU).
// The product is formed at issue; the selected W-bit result and the RS tag
// then travel through LATENCY elastic stages, the last of which drives the
// CDB port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mul_pipe_unit_if.slave (issue port, flush, CDB port, busy)
// Parameters: BW_PROCESSOR_DATA (operand width), BW_TAG (RS tag width),
//             LATENCY (stages from accept to result valid, 1..8).
module mul_pipe_unit
   import mul_pkg::*;
#(
   parameter int BW_PROCESSOR_DATA = MUL_DATA_W,
   parameter int BW_TAG            = 1,
   parameter int LATENCY           = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   mul_pipe_unit_if.slave bus
);

   localparam int W     = BW_PROCESSOR_DATA;
   localparam int PL_BW = BW_TAG + W;

   logic [W-1:0]       issue_rs1;
   logic [W-1:0]       issue_rs2;
   logic [W-1:0]       issue_result;
   logic [LATENCY-1:0] stg_valid;

   assign issue_rs1    = bus.i_rsv_V_flatten[W-1:0];
   assign issue_rs2    = bus.i_rsv_V_flatten[2*W-1:W];
   assign issue_result = mul_select(mul_op_e'(bus.i_rsv_op), issue_rs1, issue_rs2);

   // Each stage keeps its own valid/adv nets so the ready chain is a plain
   // combinational path from o_cdb_ready back to i_rsv_ready.
   for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      logic             in_valid;
      logic [PL_BW-1:0] in_payload;
      logic             adv_next;
      logic             valid;
      logic [PL_BW-1:0] payload;
      logic             adv;

      if (k == 0) begin : g_from_issue
         assign in_valid   = bus.i_rsv_valid;
         assign in_payload = {bus.i_rsv_tag, issue_result};
      end else begin : g_from_stage
         assign in_valid   = g_stage[k-1].valid;
         assign in_payload = g_stage[k-1].payload;
      end

      if (k == LATENCY - 1) begin : g_to_cdb
         assign adv_next = bus.o_cdb_ready;
      end else begin : g_to_stage
         assign adv_next = g_stage[k+1].adv;
      end

      pipe_stage_slice #(
         .PAYLOAD_BW (PL_BW)
      ) u_slice (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_valid    (in_valid),
         .i_payload  (in_payload),
         .i_adv_next (adv_next),
         .i_flush    (bus.i_flush),
         .o_valid    (valid),
         .o_payload  (payload),
         .o_adv      (adv)
      );

      assign stg_valid[k] = valid;
   end

   assign bus.i_rsv_ready                   = g_stage[0].adv;
   assign bus.o_cdb_valid                   = g_stage[LATENCY-1].valid;
   assign {bus.o_cdb_tag, bus.o_cdb_wdata}  = g_stage[LATENCY-1].payload;
   assign bus.o_busy                        = |stg_valid;

endmodule
